conv_mac_seq: RTL

Sequencer for the serial shift-add multiplier and accumulator in the convolution datapath. For each output pixel it steps through N_TAPS kernel taps. For each tap it loads the multiplier operands, shifts the multiplier for OP_WIDTH cycles, then accumulates the product. It then presents the finished sum with a valid/ready handshake. It owns all tap and bit counting, so the datapath holds no control state.

---
 rtl/conv_mac_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/conv_mac_seq.sv
// Control sequencer for the serial shift-add multiplier and accumulator: tap/bit counting, strobes, result handshake.
// Optional build macro CONV_MAC_SEQ_BACK2BACK_EN lets DONE launch the next pixel directly when i_start is held.
module conv_mac_seq #(
  parameter  int N_TAPS   = 9,
  parameter  int OP_WIDTH = 8,
  localparam int TW       = (N_TAPS > 2) ? $clog2(N_TAPS) : 1,
  localparam int BW       = (OP_WIDTH > 2) ? $clog2(OP_WIDTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_arstn,
  input  logic          i_start,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic          i_ready,
  output logic          o_busy,
  output logic [TW-1:0] o_tap_idx,
  output logic [BW-1:0] o_bit_idx,
  output logic          o_mul_load,
  output logic          o_mul_shift,
  output logic          o_acc_clr,
  output logic          o_acc_en,
  output logic          o_valid
);

  // state   | meaning
  // S_IDLE  | waiting for i_start, counters at 0
  // S_LOAD  | load multiplier operands (and clear accumulator on tap 0)
  // S_SHIFT | one shift-add step per cycle, bit_idx 0..OP_WIDTH-1
  // S_ACC   | add product into accumulator, then next tap or finish
  // S_DONE  | result valid, waiting for i_ready
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ACC,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          tap_last, bit_last;

  assign tap_last = (tap_q == TW'(N_TAPS - 1));
  assign bit_last = (bit_q == BW'(OP_WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    bit_d   = bit_q;
    if (i_clear) begin
      state_d = S_IDLE;
      tap_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_LOAD;
            tap_d   = '0;
            bit_d   = '0;
          end
        end
        S_LOAD: begin
          if (i_en) begin
            state_d = S_SHIFT;
            bit_d   = '0;
          end
        end
        S_SHIFT: begin
          if (i_en) begin
            if (bit_last) begin
              state_d = S_ACC;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        S_ACC: begin
          if (i_en) begin
            if (tap_last) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              tap_d   = tap_q + TW'(1);
            end
          end
        end
        S_DONE: begin
          if (i_ready) begin
            tap_d = '0;
            bit_d = '0;
`ifdef CONV_MAC_SEQ_BACK2BACK_EN
            state_d = i_start ? S_LOAD : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end
        end
        default: begin
          state_d = S_IDLE;
          tap_d   = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  // Datapath strobes are gated by i_en so a stalled cycle never moves the datapath.
  assign o_busy      = (state_q != S_IDLE);
  assign o_tap_idx   = tap_q;
  assign o_bit_idx   = bit_q;
  assign o_mul_load  = (state_q == S_LOAD) && i_en;
  assign o_acc_clr   = (state_q == S_LOAD) && i_en && (tap_q == '0);
  assign o_mul_shift = (state_q == S_SHIFT) && i_en;
  assign o_acc_en    = (state_q == S_ACC) && i_en;
  assign o_valid     = (state_q == S_DONE);

endmodule
